mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported, Wishbone-style memory bus between the instruction-fetch side (pc_reg/if_id) and the data side (mem stage) of the five-stage core. It grants the bus to one requester at a time and runs one bus cycle per grant. A watchdog ends any bus cycle that is never acknowledged. Whenever a requester is waiting, the arbiter drives a stall request to the pipeline controller.

---
 rtl/mem_arbiter_pkg.sv | 40 ++++
 rtl/mem_arbiter_bus_watchdog.sv | 28 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

    localparam int REG_BUS       = 32;
    localparam int INST_ADDR_BUS = 32;
    localparam int WD_WIDTH      = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    typedef struct packed {
        logic                     we;
        logic [INST_ADDR_BUS-1:0] addr;
        logic [3:0]               sel;
        logic [REG_BUS-1:0]       wdata;
    } bus_req_t;

    function automatic bus_req_t make_bus_req(
        input logic                     we,
        input logic [INST_ADDR_BUS-1:0] addr,
        input logic [3:0]               sel,
        input logic [REG_BUS-1:0]       wdata
    );
        bus_req_t r;
        r.we    = we;
        r.addr  = addr;
        r.sel   = sel;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_bus_watchdog.sv
// Wait-cycle counter for an outstanding bus cycle; flags when the
// configured limit is reached.
module mem_arbiter_bus_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter logic [WD_WIDTH-1:0] TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WD_WIDTH-1:0] count_q;

    // Count unacknowledged bus cycles; cleared whenever no cycle is open.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == TIMEOUT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one Wishbone-style bus between instruction fetch and the data
// stage. Data side wins ties; one bus cycle per grant; a watchdog closes
// cycles the slave never acknowledges.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | bus free; grant mem, else if, and latch its bus request
// ARB_BUS  | cyc/stb high; wait for bus_ack_i or watchdog expiry
// ARB_DONE | one-cycle ack (and err) to the granted port, then idle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     if_req_i,
    input  logic [INST_ADDR_BUS-1:0] if_addr_i,
    output logic [REG_BUS-1:0]       if_rdata_o,
    output logic                     if_ack_o,
    output logic                     if_err_o,

    input  logic                     mem_req_i,
    input  logic                     mem_we_i,
    input  logic [INST_ADDR_BUS-1:0] mem_addr_i,
    input  logic [3:0]               mem_sel_i,
    input  logic [REG_BUS-1:0]       mem_wdata_i,
    output logic [REG_BUS-1:0]       mem_rdata_o,
    output logic                     mem_ack_o,
    output logic                     mem_err_o,

    output logic                     bus_cyc_o,
    output logic                     bus_stb_o,
    output logic                     bus_we_o,
    output logic [INST_ADDR_BUS-1:0] bus_addr_o,
    output logic [3:0]               bus_sel_o,
    output logic [REG_BUS-1:0]       bus_wdata_o,
    input  logic [REG_BUS-1:0]       bus_rdata_i,
    input  logic                     bus_ack_i,

    output logic                     stallreq_o
);

    localparam logic [WD_WIDTH-1:0] TIMEOUT_CNT = TIMEOUT[WD_WIDTH-1:0];

    arb_state_e         state_q, state_d;
    grant_e             grant_q;
    bus_req_t           bus_q;
    logic [REG_BUS-1:0] rdata_q;
    logic               err_q;
    logic               wd_expired;
    logic               in_bus;
    logic               in_done;

    assign in_bus  = (state_q == ARB_BUS);
    assign in_done = (state_q == ARB_DONE);

    mem_arbiter_bus_watchdog #(
        .TIMEOUT (TIMEOUT_CNT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_bus),
        .en      (in_bus && !bus_ack_i),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack in the expiry cycle still counts as success.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (mem_req_i || if_req_i) begin
                    state_d = ARB_BUS;
                end
            end
            ARB_BUS: begin
                if (bus_ack_i || wd_expired) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Grant, latched bus request, and completion data/status.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= GRANT_IF;
            bus_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (mem_req_i) begin
                        grant_q <= GRANT_MEM;
                        bus_q   <= make_bus_req(mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i);
                        err_q   <= 1'b0;
                    end else if (if_req_i) begin
                        grant_q <= GRANT_IF;
                        bus_q   <= make_bus_req(1'b0, if_addr_i, 4'hF, {REG_BUS{1'b0}});
                        err_q   <= 1'b0;
                    end
                end
                ARB_BUS: begin
                    if (bus_ack_i) begin
                        rdata_q <= bus_q.we ? {REG_BUS{1'b0}} : bus_rdata_i;
                    end else if (wd_expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_cyc_o   = in_bus;
    assign bus_stb_o   = in_bus;
    assign bus_we_o    = bus_q.we;
    assign bus_addr_o  = bus_q.addr;
    assign bus_sel_o   = bus_q.sel;
    assign bus_wdata_o = bus_q.wdata;

    assign if_ack_o    = in_done && (grant_q == GRANT_IF);
    assign mem_ack_o   = in_done && (grant_q == GRANT_MEM);
    assign if_err_o    = if_ack_o && err_q;
    assign mem_err_o   = mem_ack_o && err_q;
    assign if_rdata_o  = if_ack_o  ? rdata_q : '0;
    assign mem_rdata_o = mem_ack_o ? rdata_q : '0;

    assign stallreq_o  = (if_req_i && !if_ack_o) || (mem_req_i && !mem_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// and a scripted slave whose ack delay is set per test.
module tb_mem_arbiter;

    localparam int TB_TIMEOUT = 4;
    localparam logic P_IF  = 1'b0;
    localparam logic P_MEM = 1'b1;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        if_err_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        mem_err_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stallreq_o;

    int n_pass  = 0;
    int n_total = 0;
    int cyc_n   = 0;
    bit cmp_en  = 0;

    int          wait_cfg   = 0;
    bit          stray_ack  = 0;
    logic [31:0] slave_word = 32'h0;
    int          slv_cnt    = 0;

    mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .if_err_o    (if_err_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sel_i   (mem_sel_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ack_o   (mem_ack_o),
        .mem_err_o   (mem_err_o),
        .bus_cyc_o   (bus_cyc_o),
        .bus_stb_o   (bus_stb_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .stallreq_o  (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    // Slave: acks on the (wait_cfg+1)-th strobe cycle; optional stray acks when idle.
    assign bus_rdata_i = slave_word;
    always @(negedge clk) begin
        if (bus_stb_o === 1'b1) begin
            bus_ack_i <= (slv_cnt == wait_cfg);
            slv_cnt   <= slv_cnt + 1;
        end else begin
            bus_ack_i <= stray_ack;
            slv_cnt   <= 0;
        end
    end

    // Reference model: a granted transaction occupies min(wait,TIMEOUT)+1
    // strobe cycles followed by one ack cycle, then one idle cycle.
    function automatic int stb_len(input int w);
        return ((w < TB_TIMEOUT) ? w : TB_TIMEOUT) + 1;
    endfunction

    int          m_left = 0;
    logic        m_port = P_IF;
    logic        m_we   = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [3:0]  m_sel  = 4'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_err  = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    bit          if_pend  = 0;
    bit          mem_pend = 0;
    logic [31:0] if_hold  = 32'h0;
    logic [68:0] mem_hold = 69'h0;

    logic e_stb, e_if_ack, e_mem_ack, e_stall;
    assign e_stb     = (m_left >= 2);
    assign e_if_ack  = (m_left == 1) && (m_port == P_IF);
    assign e_mem_ack = (m_left == 1) && (m_port == P_MEM);
    assign e_stall   = (if_req_i && !e_if_ack) || (mem_req_i && !e_mem_ack);

    always @(posedge clk) begin
        if (rst) begin
            m_left   <= 0;
            if_pend  <= 0;
            mem_pend <= 0;
        end else begin
            if (if_pend)
                check("if_req_held", {31'b0, (if_req_i === 1'b1) && (if_addr_i === if_hold)}, 32'd1);
            if (mem_pend)
                check("mem_req_held", {31'b0, (mem_req_i === 1'b1) &&
                      ({mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i} === mem_hold)}, 32'd1);
            if_pend  <= e_if_ack  ? 1'b0 : if_req_i;
            mem_pend <= e_mem_ack ? 1'b0 : mem_req_i;
            if_hold  <= if_addr_i;
            mem_hold <= {mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i};
            if (m_left > 0) begin
                m_left <= m_left - 1;
            end else if (mem_req_i) begin
                m_left  <= stb_len(wait_cfg) + 1;
                m_port  <= P_MEM;
                m_we    <= mem_we_i;
                m_addr  <= mem_addr_i;
                m_sel   <= mem_sel_i;
                m_wdata <= mem_wdata_i;
                m_err   <= (wait_cfg > TB_TIMEOUT);
                m_rdata <= ((wait_cfg > TB_TIMEOUT) || mem_we_i) ? 32'h0 : slave_word;
            end else if (if_req_i) begin
                m_left  <= stb_len(wait_cfg) + 1;
                m_port  <= P_IF;
                m_we    <= 1'b0;
                m_addr  <= if_addr_i;
                m_sel   <= 4'hF;
                m_wdata <= 32'h0;
                m_err   <= (wait_cfg > TB_TIMEOUT);
                m_rdata <= (wait_cfg > TB_TIMEOUT) ? 32'h0 : slave_word;
            end
        end
    end

    // Compare DUT outputs against the model every cycle once reset has been applied.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc",     bus_cyc_o,  e_stb);
            check("stb",     bus_stb_o,  e_stb);
            check("if_ack",  if_ack_o,   e_if_ack);
            check("mem_ack", mem_ack_o,  e_mem_ack);
            check("if_err",  if_err_o,   e_if_ack && m_err);
            check("mem_err", mem_err_o,  e_mem_ack && m_err);
            check("stall",   stallreq_o, e_stall);
            if (e_stb) begin
                check("bus_we",   bus_we_o,   m_we);
                check("bus_addr", bus_addr_o, m_addr);
                check("bus_sel",  bus_sel_o,  m_sel);
                if (m_we) check("bus_wdata", bus_wdata_o, m_wdata);
            end
            if (e_if_ack)  check("if_rdata",  if_rdata_o,  m_rdata);
            if (e_mem_ack) check("mem_rdata", mem_rdata_o, m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        if_req_i    = 1'b0;
        if_addr_i   = 32'h0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_addr_i  = 32'h0;
        mem_sel_i   = 4'h0;
        mem_wdata_i = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"},   bus_cyc_o,   0);
        check({tag, "_stb"},   bus_stb_o,   0);
        check({tag, "_we"},    bus_we_o,    0);
        check({tag, "_addr"},  bus_addr_o,  0);
        check({tag, "_sel"},   bus_sel_o,   0);
        check({tag, "_wdata"}, bus_wdata_o, 0);
        check({tag, "_acks"},  {if_ack_o, if_err_o, mem_ack_o, mem_err_o}, 0);
        check({tag, "_ird"},   if_rdata_o,  0);
        check({tag, "_mrd"},   mem_rdata_o, 0);
        check({tag, "_stall"}, stallreq_o,  0);
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        tick();
        tick();
        cmp_en = 1;
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Single zero-wait fetch.
        slave_word = 32'h34011100;
        wait_cfg   = 0;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0010;
        @(negedge clk);
        check("fetch_stall_t", stallreq_o, 1);
        check("fetch_stb_t",   bus_stb_o,  0);
        @(negedge clk);
        check("fetch_stb_t1",   bus_stb_o,  1);
        check("fetch_addr_t1",  bus_addr_o, 32'h10);
        check("fetch_stall_t1", stallreq_o, 1);
        @(negedge clk);
        check("fetch_ack_t2",   if_ack_o,   1);
        check("fetch_rdata_t2", if_rdata_o, 32'h34011100);
        tick();
        clear_reqs();
        tick();

        // Simultaneous requests: mem write first, fetch after.
        slave_word  = 32'hCAFE_F00D;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = 32'h80;
        mem_sel_i   = 4'b0011;
        mem_wdata_i = 32'hDEAD_BEEF;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h20;
        @(negedge clk);
        @(negedge clk);
        check("sim_we_t1",    bus_we_o,    1);
        check("sim_addr_t1",  bus_addr_o,  32'h80);
        check("sim_sel_t1",   bus_sel_o,   4'b0011);
        check("sim_wdata_t1", bus_wdata_o, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sim_mack_t2",  mem_ack_o,   1);
        check("sim_mrd_t2",   mem_rdata_o, 0);
        check("sim_iack_t2",  if_ack_o,    0);
        tick();
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_sel_i = 4'h0; mem_wdata_i = 32'h0;
        @(negedge clk);
        check("sim_stb_t3", bus_stb_o, 0);
        @(negedge clk);
        check("sim_stb_t4",  bus_stb_o,  1);
        check("sim_addr_t4", bus_addr_o, 32'h20);
        check("sim_sel_t4",  bus_sel_o,  4'hF);
        @(negedge clk);
        check("sim_iack_t5", if_ack_o,   1);
        check("sim_ird_t5",  if_rdata_o, 32'hCAFE_F00D);
        tick();
        clear_reqs();
        tick();

        // Three wait states, with stray acks while the bus is idle.
        stray_ack  = 1;
        wait_cfg   = 3;
        slave_word = 32'h1357_2468;
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h44;
        mem_sel_i  = 4'b1100;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("wait_stb",  bus_stb_o,  1);
            check("wait_addr", bus_addr_o, 32'h44);
            check("wait_mack", mem_ack_o,  0);
        end
        @(negedge clk);
        check("wait_mack_t5", mem_ack_o,   1);
        check("wait_mrd_t5",  mem_rdata_o, 32'h1357_2468);
        check("wait_merr_t5", mem_err_o,   0);
        tick();
        clear_reqs();
        tick();
        tick();
        stray_ack = 0;

        // Ack arriving in the last allowed cycle wins over the timeout.
        wait_cfg   = TB_TIMEOUT;
        slave_word = 32'h0BAD_F00D;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h30;
        repeat (6) @(negedge clk);
        check("edge_stb_t5", bus_stb_o, 1);
        @(negedge clk);
        check("edge_iack_t6", if_ack_o,   1);
        check("edge_ierr_t6", if_err_o,   0);
        check("edge_ird_t6",  if_rdata_o, 32'h0BAD_F00D);
        tick();
        clear_reqs();
        tick();

        // Timeout on a mem read while a fetch waits behind it.
        wait_cfg   = 50;
        slave_word = 32'hFFFF_FFFF;
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h100;
        mem_sel_i  = 4'hF;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h24;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("to_stb", bus_stb_o, 1);
        end
        @(negedge clk);
        check("to_mack_t6",  mem_ack_o,   1);
        check("to_merr_t6",  mem_err_o,   1);
        check("to_mrd_t6",   mem_rdata_o, 0);
        check("to_stall_t6", stallreq_o,  1);
        tick();
        mem_req_i = 1'b0; mem_addr_i = 32'h0; mem_sel_i = 4'h0;
        wait_cfg  = 0;
        slave_word = 32'h2222_3333;
        @(negedge clk);
        @(negedge clk);
        check("to_if_addr_t8", bus_addr_o, 32'h24);
        @(negedge clk);
        check("to_iack_t9", if_ack_o,   1);
        check("to_ierr_t9", if_err_o,   0);
        check("to_ird_t9",  if_rdata_o, 32'h2222_3333);
        tick();
        clear_reqs();
        tick();

        // Reset during an open bus cycle.
        wait_cfg   = 50;
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h200;
        mem_sel_i  = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_stb_t1", bus_stb_o, 1);
        tick();
        rst = 1'b1;
        clear_reqs();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("rstmid");
        tick();
        rst = 1'b0;
        tick();
        wait_cfg   = 0;
        slave_word = 32'hA5A5_5A5A;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h40;
        @(negedge clk);
        @(negedge clk);
        check("post_addr_t1", bus_addr_o, 32'h40);
        @(negedge clk);
        check("post_iack_t2", if_ack_o,   1);
        check("post_ird_t2",  if_rdata_o, 32'hA5A5_5A5A);
        check("post_mack_t2", mem_ack_o,  0);
        tick();
        clear_reqs();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
